// File: rtl/ahb3lite_interconnect_master_port.sv
// Purpose: master-facing port of the AHB3-Lite multi-layer switch; decodes, holds and routes transfers.
// Latency: zero-cycle pass-through when the target slave port grants; otherwise one or more stall cycles.
// Backpressure: HREADYOUT low while a held address phase waits for a grant, and during the first ERROR cycle.
module ahb3lite_interconnect_master_port #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int SLAVES     = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,

  // master side
  input  logic                           HSEL,
  input  logic [HADDR_SIZE-1:0]          HADDR,
  input  logic [HDATA_SIZE-1:0]          HWDATA,
  output logic [HDATA_SIZE-1:0]          HRDATA,
  input  logic                           HWRITE,
  input  logic [2:0]                     HSIZE,
  input  logic [2:0]                     HBURST,
  input  logic [3:0]                     HPROT,
  input  logic [1:0]                     HTRANS,
  input  logic                           HMASTLOCK,
  input  logic                           HREADY,
  output logic                           HREADYOUT,
  output logic                           HRESP,

  // address map, one base/mask pair per slave port
  input  logic [SLAVES*HADDR_SIZE-1:0]   slvHADDRbase,
  input  logic [SLAVES*HADDR_SIZE-1:0]   slvHADDRmask,

  // slave-port side
  output logic [SLAVES-1:0]              slvHSEL,
  output logic [HADDR_SIZE-1:0]          slvHADDR,
  output logic [HDATA_SIZE-1:0]          slvHWDATA,
  input  logic [SLAVES*HDATA_SIZE-1:0]   slvHRDATA,
  output logic                           slvHWRITE,
  output logic [2:0]                     slvHSIZE,
  output logic [2:0]                     slvHBURST,
  output logic [3:0]                     slvHPROT,
  output logic [1:0]                     slvHTRANS,
  output logic                           slvHMASTLOCK,
  output logic                           slvHREADY,
  input  logic [SLAVES-1:0]              slvHREADYOUT,
  input  logic [SLAVES-1:0]              slvHRESP,
  input  logic [SLAVES-1:0]              granted,
  output logic [SLAVES-1:0]              can_switch
);

  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PENDING,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // data-phase owner
  logic [SW-1:0]         r_dsel;

  // holding register for a stalled address phase
  logic [SW-1:0]         r_hold_sel;
  logic [HADDR_SIZE-1:0] r_hold_addr;
  logic                  r_hold_write;
  logic [2:0]            r_hold_size;
  logic [2:0]            r_hold_burst;
  logic [3:0]            r_hold_prot;
  logic [1:0]            r_hold_trans;
  logic                  r_hold_lock;

  // unpacked views of the flattened per-slave buses
  logic [HADDR_SIZE-1:0] w_base  [SLAVES];
  logic [HADDR_SIZE-1:0] w_mask  [SLAVES];
  logic [HDATA_SIZE-1:0] w_rdata [SLAVES];
  logic [SLAVES-1:0]     w_hit;

  logic [SW-1:0]         w_tgt;
  logic                  w_map;
  logic                  w_access;
  logic                  w_tgt_go;
  logic                  w_hold_go;
  logic                  w_accept;
  logic                  w_pass;
  logic                  w_capture;
  logic                  w_live_hold;
  logic                  w_reg_hold;

  genvar g;
  generate
    for (g = 0; g < SLAVES; g++) begin : g_unpack
      assign w_base[g]  = slvHADDRbase[g*HADDR_SIZE +: HADDR_SIZE];
      assign w_mask[g]  = slvHADDRmask[g*HADDR_SIZE +: HADDR_SIZE];
      assign w_rdata[g] = slvHRDATA[g*HDATA_SIZE +: HDATA_SIZE];
      assign w_hit[g]   = ((HADDR ^ w_base[g]) & w_mask[g]) == '0;
    end
  endgenerate

  assign w_map     = |w_hit;
  assign w_access  = HSEL & HREADY & HTRANS[1];
  assign w_tgt_go  = granted[w_tgt] & slvHREADYOUT[w_tgt];
  assign w_hold_go = granted[r_hold_sel] & slvHREADYOUT[r_hold_sel];
  assign slvHWDATA = HWDATA;

  // Priority decode of the live address: the lowest matching slave index wins.
  always_comb begin
    w_tgt = '0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if (w_hit[s]) w_tgt = SW'(s);
    end
  end

  // State register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and master-side response; w_accept marks cycles in which a new address phase may be taken.
  always_comb begin
    w_state_nxt = r_state;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = '0;
    w_accept    = 1'b0;
    w_pass      = 1'b0;
    w_capture   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_accept = 1'b1;
      end
      ST_PENDING: begin
        HREADYOUT = 1'b0;
        if (w_hold_go) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        HREADYOUT = slvHREADYOUT[r_dsel];
        HRESP     = slvHRESP[r_dsel];
        HRDATA    = w_rdata[r_dsel];
        w_accept  = slvHREADYOUT[r_dsel];
      end
      ST_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP    = 1'b1;
        w_accept = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_accept) begin
      if (!w_access) begin
        w_state_nxt = ST_IDLE;
      end else if (!w_map) begin
        w_state_nxt = ST_ERR1;
      end else if (w_tgt_go) begin
        w_pass      = 1'b1;
        w_state_nxt = ST_DATA;
      end else begin
        w_capture   = 1'b1;
        w_state_nxt = ST_PENDING;
      end
    end
  end

  // Data-phase owner: set when an address phase is actually handed to a slave port.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_dsel <= '0;
    end else if (w_pass) begin
      r_dsel <= w_tgt;
    end else if (r_state == ST_PENDING && w_hold_go) begin
      r_dsel <= r_hold_sel;
    end
  end

  // Holding register: captures the address phase whose target has not granted yet.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_hold_sel   <= '0;
      r_hold_addr  <= '0;
      r_hold_write <= 1'b0;
      r_hold_size  <= '0;
      r_hold_burst <= '0;
      r_hold_prot  <= '0;
      r_hold_trans <= HTRANS_IDLE;
      r_hold_lock  <= 1'b0;
    end else if (w_capture) begin
      r_hold_sel   <= w_tgt;
      r_hold_addr  <= HADDR;
      r_hold_write <= HWRITE;
      r_hold_size  <= HSIZE;
      r_hold_burst <= HBURST;
      r_hold_prot  <= HPROT;
      r_hold_trans <= HTRANS;
      r_hold_lock  <= HMASTLOCK;
    end
  end

  // Slave-side address/control: held copy while pending (SEQ restarts as NONSEQ there), live bus otherwise.
  always_comb begin
    slvHSEL      = '0;
    slvHADDR     = HADDR;
    slvHWRITE    = HWRITE;
    slvHSIZE     = HSIZE;
    slvHBURST    = HBURST;
    slvHPROT     = HPROT;
    slvHTRANS    = HTRANS;
    slvHMASTLOCK = HMASTLOCK;
    slvHREADY    = HREADY;

    if (r_state == ST_PENDING) begin
      slvHSEL[r_hold_sel] = 1'b1;
      slvHADDR            = r_hold_addr;
      slvHWRITE           = r_hold_write;
      slvHSIZE            = r_hold_size;
      slvHBURST           = r_hold_burst;
      slvHPROT            = r_hold_prot;
      slvHTRANS           = (r_hold_trans == HTRANS_SEQ) ? HTRANS_NONSEQ : r_hold_trans;
      slvHMASTLOCK        = r_hold_lock;
      slvHREADY           = 1'b1;
    end else if (w_pass) begin
      slvHSEL[w_tgt] = 1'b1;
    end
  end

  assign w_live_hold = HSEL & w_map &
                       (HMASTLOCK | (HTRANS == HTRANS_SEQ) | (HTRANS == HTRANS_BUSY));
  assign w_reg_hold  = (r_state == ST_PENDING) &
                       (r_hold_lock | (r_hold_trans == HTRANS_SEQ) | (r_hold_trans == HTRANS_BUSY));

  // A slave port must not re-arbitrate away while this master is mid-burst or locked on it.
  always_comb begin
    can_switch = '1;
    if (w_live_hold) can_switch[w_tgt]      = 1'b0;
    if (w_reg_hold)  can_switch[r_hold_sel] = 1'b0;
  end

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Bench for ahb3lite_interconnect_master_port: table vectors, directed corner sequences, randomized run vs model.
// Inputs change on the falling edge and outputs are sampled 1 time unit later.
// HREADY is looped back from HREADYOUT, as on a single-master layer.
module tb_ahb3lite_interconnect_master_port;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 8;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              HSEL;
  logic [AW-1:0]     HADDR;
  logic [DW-1:0]     HWDATA;
  logic [DW-1:0]     HRDATA;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [1:0]        HTRANS;
  logic              HMASTLOCK;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [NS*AW-1:0]  slvHADDRbase;
  logic [NS*AW-1:0]  slvHADDRmask;
  logic [NS-1:0]     slvHSEL;
  logic [AW-1:0]     slvHADDR;
  logic [DW-1:0]     slvHWDATA;
  logic [NS*DW-1:0]  slvHRDATA;
  logic              slvHWRITE;
  logic [2:0]        slvHSIZE;
  logic [2:0]        slvHBURST;
  logic [3:0]        slvHPROT;
  logic [1:0]        slvHTRANS;
  logic              slvHMASTLOCK;
  logic              slvHREADY;
  logic [NS-1:0]     slvHREADYOUT;
  logic [NS-1:0]     slvHRESP;
  logic [NS-1:0]     granted;
  logic [NS-1:0]     can_switch;

  logic [AW-1:0] base_a  [NS];
  logic [AW-1:0] mask_a  [NS];
  logic [DW-1:0] rdata_a [NS];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;

  for (genvar k = 0; k < NS; k++) begin : g_pack
    assign slvHADDRbase[k*AW +: AW] = base_a[k];
    assign slvHADDRmask[k*AW +: AW] = mask_a[k];
    assign slvHRDATA[k*DW +: DW]    = rdata_a[k];
  end

  ahb3lite_interconnect_master_port #(
    .HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .slvHADDRbase(slvHADDRbase), .slvHADDRmask(slvHADDRmask),
    .slvHSEL(slvHSEL), .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA),
    .slvHRDATA(slvHRDATA), .slvHWRITE(slvHWRITE), .slvHSIZE(slvHSIZE),
    .slvHBURST(slvHBURST), .slvHPROT(slvHPROT), .slvHTRANS(slvHTRANS),
    .slvHMASTLOCK(slvHMASTLOCK), .slvHREADY(slvHREADY),
    .slvHREADYOUT(slvHREADYOUT), .slvHRESP(slvHRESP),
    .granted(granted), .can_switch(can_switch)
  );

  typedef struct packed {
    logic        sel;
    logic [1:0]  tr;
    logic        lk;
    logic [31:0] a;
    logic [7:0]  exp_sel;
    logic [7:0]  exp_cs;
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] tr, input logic lk, input logic [31:0] a);
    HSEL      = s;
    HTRANS    = tr;
    HMASTLOCK = lk;
    HADDR     = a;
    HWRITE    = 1'b1;
    HSIZE     = 3'b010;
    HBURST    = 3'b000;
    HPROT     = 4'b0011;
  endtask

  task automatic drive_idle();
    drive(1'b1, 2'b00, 1'b0, 32'h0);
  endtask

  // Address map straight from the base/mask rule; the first matching index wins.
  function automatic int decode(input logic [31:0] a);
    for (int s = 0; s < NS; s++) begin
      if (((a ^ base_a[s]) & mask_a[s]) == 32'h0) return s;
    end
    return -1;
  endfunction

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // model state for the randomized run
  logic        m_pv;
  logic [2:0]  m_pt;
  logic [31:0] m_pa;
  logic [1:0]  m_ptr;
  logic        m_plk;
  logic        m_dv;
  logic [2:0]  m_ds;
  int          m_err;

  initial begin
    logic [31:0] hw;
    logic        prev_rdy;

    for (int s = 0; s < 7; s++) begin
      base_a[s] = 32'(s) << 28;
      mask_a[s] = 32'hF000_0000;
    end
    base_a[7] = 32'h6100_0000;   // overlaps slave 6, which must win
    mask_a[7] = 32'hFF00_0000;
    for (int s = 0; s < NS; s++) rdata_a[s] = 32'hD000_0000 | 32'(s);

    HRESETn      = 1'b0;
    HWDATA       = '0;
    granted      = '1;
    slvHREADYOUT = '1;
    slvHRESP     = '0;
    drive_idle();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    chk("rst_slvhsel", slvHSEL, 0);
    chk("rst_can_switch", can_switch, 8'hFF);
    chk("rst_hrdata", HRDATA, 0);

    // sel, trans, lock, addr, exp slvHSEL, exp can_switch, exp data-phase ready/resp/rdata
    tbl[0] = '{1'b1, 2'b10, 1'b0, 32'h2000_0010, 8'h04, 8'hFF, 1'b1, 1'b0, 32'hD000_0002};
    tbl[1] = '{1'b1, 2'b10, 1'b0, 32'hF000_0000, 8'h00, 8'hFF, 1'b0, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 2'b00, 1'b0, 32'h2000_0000, 8'h00, 8'hFF, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 2'b01, 1'b0, 32'h3000_0000, 8'h00, 8'hF7, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 2'b11, 1'b0, 32'h1000_0004, 8'h02, 8'hFD, 1'b1, 1'b0, 32'hD000_0001};
    tbl[5] = '{1'b1, 2'b10, 1'b1, 32'h1000_0000, 8'h02, 8'hFD, 1'b1, 1'b0, 32'hD000_0001};
    tbl[6] = '{1'b1, 2'b10, 1'b0, 32'h6100_0000, 8'h40, 8'hFF, 1'b1, 1'b0, 32'hD000_0006};
    tbl[7] = '{1'b0, 2'b10, 1'b0, 32'h2000_0000, 8'h00, 8'hFF, 1'b1, 1'b0, 32'h0};
    tbl[8] = '{1'b1, 2'b10, 1'b0, 32'h0000_0000, 8'h01, 8'hFF, 1'b1, 1'b0, 32'hD000_0000};
    tbl[9] = '{1'b1, 2'b10, 1'b0, 32'h7000_0000, 8'h00, 8'hFF, 1'b0, 1'b1, 32'h0};

    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      drive(tbl[i].sel, tbl[i].tr, tbl[i].lk, tbl[i].a);
      hw     = $urandom;
      HWDATA = hw;
      #1;
      chk($sformatf("tbl%0d_slvhsel", i), slvHSEL, tbl[i].exp_sel);
      chk($sformatf("tbl%0d_can_switch", i), can_switch, tbl[i].exp_cs);
      chk($sformatf("tbl%0d_slvhwdata", i), slvHWDATA, hw);
      @(negedge HCLK);
      drive_idle();
      #1;
      chk($sformatf("tbl%0d_dp_hreadyout", i), HREADYOUT, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_dp_hresp", i), HRESP, tbl[i].exp_resp);
      chk($sformatf("tbl%0d_dp_hrdata", i), HRDATA, tbl[i].exp_rdata);
      repeat (2) @(negedge HCLK);
    end

    // Held address phase: slave 2 withholds its grant for three cycles while the master bus changes.
    @(negedge HCLK);
    granted = 8'hFB;
    drive(1'b1, 2'b10, 1'b0, 32'h2000_0010);
    #1;
    chk("pend_addr_slvhsel", slvHSEL, 0);
    @(negedge HCLK);
    drive(1'b1, 2'b00, 1'b0, 32'hAAAA_5555);
    HWRITE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pend%0d_hreadyout", k), HREADYOUT, 0);
      chk($sformatf("pend%0d_slvhaddr", k), slvHADDR, 32'h2000_0010);
      chk($sformatf("pend%0d_slvhsel", k), slvHSEL, 8'h04);
      chk($sformatf("pend%0d_slvhready", k), slvHREADY, 1);
      chk($sformatf("pend%0d_slvhwrite", k), slvHWRITE, 1);
      if (k == 2) granted = '1;
      @(negedge HCLK);
    end
    #1;
    chk("pend_data_hreadyout", HREADYOUT, 1);
    chk("pend_data_hrdata", HRDATA, 32'hD000_0002);

    // SEQ to a slave that has not granted is re-presented as NONSEQ.
    @(negedge HCLK);
    granted = 8'hEF;
    drive(1'b1, 2'b11, 1'b0, 32'h4000_0000);
    @(negedge HCLK);
    #1;
    chk("seq_pend_slvhtrans", slvHTRANS, 2'b10);
    chk("seq_pend_slvhsel", slvHSEL, 8'h10);
    chk("seq_pend_can_switch", can_switch, 8'hEF);
    granted = '1;
    @(negedge HCLK);
    drive_idle();
    #1;
    chk("seq_data_hreadyout", HREADYOUT, 1);

    // Unmapped access: two-cycle ERROR, then OKAY.
    @(negedge HCLK);
    drive(1'b1, 2'b10, 1'b0, 32'hF000_0000);
    #1;
    chk("err_addr_slvhsel", slvHSEL, 0);
    @(negedge HCLK);
    drive_idle();
    #1;
    chk("err1_hready_hresp", {HREADYOUT, HRESP}, 2'b01);
    chk("err1_slvhsel", slvHSEL, 0);
    @(negedge HCLK);
    #1;
    chk("err2_hready_hresp", {HREADYOUT, HRESP}, 2'b11);
    chk("err2_slvhsel", slvHSEL, 0);
    @(negedge HCLK);
    #1;
    chk("err_done_hready_hresp", {HREADYOUT, HRESP}, 2'b10);

    // Locked transfer pins slave 1; releasing the lock on an IDLE frees it.
    @(negedge HCLK);
    drive(1'b1, 2'b10, 1'b1, 32'h1000_0000);
    #1;
    chk("lock_can_switch", can_switch, 8'hFD);
    @(negedge HCLK);
    drive(1'b1, 2'b00, 1'b0, 32'h1000_0000);
    #1;
    chk("unlock_can_switch", can_switch, 8'hFF);

    // Reset while an address phase is held.
    @(negedge HCLK);
    granted = 8'hFB;
    drive(1'b1, 2'b10, 1'b0, 32'h2000_0010);
    @(negedge HCLK);
    #1;
    chk("rstp_pending_hreadyout", HREADYOUT, 0);
    drive_idle();
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    chk("rstp_slvhsel", slvHSEL, 0);
    chk("rstp_hreadyout", HREADYOUT, 1);
    chk("rstp_hresp", HRESP, 0);
    granted = '1;

    // Randomized run against a transaction-level model.
    m_pv = 1'b0; m_pt = '0; m_pa = '0; m_ptr = '0; m_plk = 1'b0;
    m_dv = 1'b0; m_ds = '0; m_err = 0;
    prev_rdy = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        rdy, exp_resp, map, access, can_acc, pass;
      logic [7:0]  exp_sel, exp_cs;
      logic [31:0] exp_rdata, exp_addr;
      logic [1:0]  exp_trans;
      int          t;

      @(negedge HCLK);
      granted      = 8'($urandom);
      slvHREADYOUT = 8'($urandom | $urandom);
      slvHRESP     = 8'($urandom & $urandom & $urandom);
      for (int s = 0; s < NS; s++) rdata_a[s] = $urandom;
      // a master may only present a new address phase after the bus was ready
      if (prev_rdy) begin
        HSEL      = ($urandom_range(0, 7) != 0);
        HTRANS    = 2'($urandom);
        HMASTLOCK = ($urandom_range(0, 3) == 0);
        HADDR     = {4'($urandom_range(0, 15)), 28'($urandom)};
        if ($urandom_range(0, 7) == 0) HADDR[31:24] = 8'h61;
        HWRITE    = 1'($urandom);
        HSIZE     = 3'($urandom);
        HBURST    = 3'($urandom);
        HPROT     = 4'($urandom);
        HWDATA    = $urandom;
      end
      #1;

      if (m_pv)            rdy = 1'b0;
      else if (m_dv)       rdy = slvHREADYOUT[m_ds];
      else if (m_err == 2) rdy = 1'b0;
      else                 rdy = 1'b1;

      t       = decode(HADDR);
      map     = (t >= 0);
      access  = HSEL && rdy && HTRANS[1];
      can_acc = !m_pv && rdy;
      pass    = can_acc && access && map && granted[t] && slvHREADYOUT[t];

      exp_sel   = m_pv ? (8'b1 << m_pt) : (pass ? (8'b1 << t) : 8'h00);
      exp_rdata = (!m_pv && m_dv) ? rdata_a[m_ds] : 32'h0;
      exp_resp  = m_pv ? 1'b0 : (m_dv ? slvHRESP[m_ds] : (m_err > 0));
      exp_addr  = m_pv ? m_pa : HADDR;
      exp_trans = m_pv ? ((m_ptr == 2'b11) ? 2'b10 : m_ptr) : HTRANS;
      exp_cs    = 8'hFF;
      if (HSEL && map && (HMASTLOCK || HTRANS == 2'b11 || HTRANS == 2'b01)) exp_cs[t] = 1'b0;
      if (m_pv && (m_plk || m_ptr == 2'b11 || m_ptr == 2'b01)) exp_cs[m_pt] = 1'b0;

      chk($sformatf("rnd%0d_hreadyout", cyc), HREADYOUT, rdy);
      chk($sformatf("rnd%0d_hresp", cyc), HRESP, exp_resp);
      chk($sformatf("rnd%0d_hrdata", cyc), HRDATA, exp_rdata);
      chk($sformatf("rnd%0d_slvhsel", cyc), slvHSEL, exp_sel);
      chk($sformatf("rnd%0d_slvhaddr", cyc), slvHADDR, exp_addr);
      chk($sformatf("rnd%0d_slvhtrans", cyc), slvHTRANS, exp_trans);
      chk($sformatf("rnd%0d_slvhready", cyc), slvHREADY, m_pv ? 1'b1 : rdy);
      chk($sformatf("rnd%0d_can_switch", cyc), can_switch, exp_cs);

      if (m_pv) begin
        if (granted[m_pt] && slvHREADYOUT[m_pt]) begin
          m_pv = 1'b0;
          m_dv = 1'b1;
          m_ds = m_pt;
        end
      end else if (can_acc) begin
        m_dv  = 1'b0;
        m_err = 0;
        if (access) begin
          if (!map) begin
            m_err = 2;
          end else if (pass) begin
            m_dv = 1'b1;
            m_ds = 3'(t);
          end else begin
            m_pv  = 1'b1;
            m_pt  = 3'(t);
            m_pa  = HADDR;
            m_ptr = HTRANS;
            m_plk = HMASTLOCK;
          end
        end
      end else if (m_err == 2) begin
        m_err = 1;
      end
      prev_rdy = rdy;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
